// File: rtl/id_stage_pipe_if.sv
// Bundle for the decode stage: IF/ID input side, register-file read port,
// ID/EX output side and hazard/statistics outputs.
interface id_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready
  // are both high; valid never waits on ready, and the producer keeps its
  // payload stable while valid is high and ready is low.
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc;
  logic [4:0]        rf_raddr1;
  logic [4:0]        rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_alu_mode;
  logic [DATA_W-1:0] out_op_a;
  logic [DATA_W-1:0] out_op_b;
  logic [DATA_W-1:0] out_store_data;
  logic [DATA_W-1:0] out_branch_pc;
  logic [4:0]        out_dest;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_branch;
  logic              out_is_imm;
  logic              out_st_or_bne;
  logic              hazard_stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_instr, in_pc, rf_rdata1, rf_rdata2, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_alu_mode, out_op_a,
           out_op_b, out_store_data, out_branch_pc, out_dest, out_reg_write,
           out_mem_to_reg, out_mem_read, out_mem_write, out_branch, out_is_imm,
           out_st_or_bne, hazard_stall, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, rf_rdata1, rf_rdata2, out_ready,
    output in_ready, rf_raddr1, rf_raddr2, out_valid, out_alu_mode, out_op_a,
           out_op_b, out_store_data, out_branch_pc, out_dest, out_reg_write,
           out_mem_to_reg, out_mem_read, out_mem_write, out_branch, out_is_imm,
           out_st_or_bne, hazard_stall, stall_cnt
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX register: decode, operand select, branch target,
// single-bubble load-use interlock and a saturating stall counter.
module id_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  id_stage_pipe_if.slave bus
);
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic is_imm;
    logic st_or_bne;
  } ctl_t;

  logic [5:0]        op;
  logic [4:0]        dest_f;
  logic [4:0]        raddr1;
  logic [4:0]        raddr2;
  ctl_t              dec_ctl;
  logic              src2_used;
  logic              load_use;
  logic              can_adv;
  logic              hazard_stall;
  logic [DATA_W-1:0] sext_imm;

  logic              out_valid_q, out_valid_d;
  ctl_t              ctl_q, ctl_d;
  logic [5:0]        alu_mode_q, alu_mode_d;
  logic [4:0]        dest_q, dest_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [DATA_W-1:0] branch_pc_q, branch_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign op       = bus.in_instr[31:26];
  assign dest_f   = bus.in_instr[25:21];
  assign sext_imm = DATA_W'($signed(bus.in_instr[15:0]));

  always_comb begin
    dec_ctl   = '0;
    src2_used = 1'b0;
    if (!op[5]) begin
      dec_ctl.reg_write = 1'b1;
      src2_used         = 1'b1;
    end else if (op[5:4] == 2'b10) begin
      dec_ctl.reg_write = 1'b1;
      dec_ctl.is_imm    = 1'b1;
    end else begin
      case (op)
        6'h30: begin
          dec_ctl.is_imm     = 1'b1;
          dec_ctl.mem_read   = 1'b1;
          dec_ctl.mem_to_reg = 1'b1;
          dec_ctl.reg_write  = 1'b1;
        end
        6'h31: begin
          dec_ctl.is_imm    = 1'b1;
          dec_ctl.mem_write = 1'b1;
          dec_ctl.st_or_bne = 1'b1;
          src2_used         = 1'b1;
        end
        6'h32: begin
          dec_ctl.branch    = 1'b1;
          dec_ctl.st_or_bne = 1'b1;
          src2_used         = 1'b1;
        end
        default: ;
      endcase
    end
    if (dest_f == 5'd0) dec_ctl.reg_write = 1'b0;
  end

  // ST and BNE read their second source through the dest field.
  assign raddr1 = bus.in_instr[20:16];
  assign raddr2 = dec_ctl.st_or_bne ? dest_f : bus.in_instr[15:11];

  assign load_use = bus.in_valid & out_valid_q & ctl_q.mem_read & (dest_q != 5'd0) &
                    ((dest_q == raddr1) | (src2_used & (dest_q == raddr2)));
  assign can_adv      = !out_valid_q | bus.out_ready;
  assign hazard_stall = load_use & !bus.flush & can_adv;

  always_comb begin
    out_valid_d  = out_valid_q;
    ctl_d        = ctl_q;
    alu_mode_d   = alu_mode_q;
    dest_d       = dest_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    store_data_d = store_data_q;
    branch_pc_d  = branch_pc_q;
    stall_cnt_d  = stall_cnt_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (can_adv) begin
      if (load_use) begin
        // The bubble clears mem_read, so the same hazard cannot repeat.
        out_valid_d = 1'b0;
        ctl_d       = '0;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (bus.in_valid) begin
        out_valid_d  = 1'b1;
        ctl_d        = dec_ctl;
        alu_mode_d   = op;
        dest_d       = dest_f;
        op_a_d       = bus.rf_rdata1;
        op_b_d       = dec_ctl.is_imm ? sext_imm : bus.rf_rdata2;
        store_data_d = bus.rf_rdata2;
        branch_pc_d  = bus.in_pc + sext_imm;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      ctl_q        <= '0;
      alu_mode_q   <= '0;
      dest_q       <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      store_data_q <= '0;
      branch_pc_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      ctl_q        <= ctl_d;
      alu_mode_q   <= alu_mode_d;
      dest_q       <= dest_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      store_data_q <= store_data_d;
      branch_pc_q  <= branch_pc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.in_ready       = bus.flush | (can_adv & !load_use);
  assign bus.hazard_stall   = hazard_stall;
  assign bus.rf_raddr1      = raddr1;
  assign bus.rf_raddr2      = raddr2;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_alu_mode   = alu_mode_q;
  assign bus.out_op_a       = op_a_q;
  assign bus.out_op_b       = op_b_q;
  assign bus.out_store_data = store_data_q;
  assign bus.out_branch_pc  = branch_pc_q;
  assign bus.out_dest       = dest_q;
  assign bus.out_reg_write  = ctl_q.reg_write;
  assign bus.out_mem_to_reg = ctl_q.mem_to_reg;
  assign bus.out_mem_read   = ctl_q.mem_read;
  assign bus.out_mem_write  = ctl_q.mem_write;
  assign bus.out_branch     = ctl_q.branch;
  assign bus.out_is_imm     = ctl_q.is_imm;
  assign bus.out_st_or_bne  = ctl_q.st_or_bne;
  assign bus.stall_cnt      = stall_cnt_q;
endmodule
